// File: rtl/seq_monitor_pkg.sv
// Shared definitions for the state-sequence monitor.
//   - Legal codes of the 3-bit sequence counter, in cycle order:
//     000 -> 001 -> 011 -> 101 -> 111 -> 010 -> 000
//   - Monitor FSM state encoding
//   - Error codes reported on err_code
//   - Helper that classifies a successor mismatch
package seq_monitor_pkg;

  // Legal counter codes in cycle order
  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b011;
  localparam logic [2:0] S3 = 3'b101;
  localparam logic [2:0] S4 = 3'b111;
  localparam logic [2:0] S5 = 3'b010;

  // Monitor FSM states
  typedef enum logic [1:0] {
    StUnsync = 2'b00,
    StLocked = 2'b01,
    StFault  = 2'b10
  } state_e;

  // Error codes
  typedef enum logic [1:0] {
    ErrNone      = 2'b00,
    ErrIllegal   = 2'b01,
    ErrWrongSucc = 2'b10,
    ErrNoEnable  = 2'b11
  } err_code_e;

  // A legal but unexpected code is a drift when the counter was neither enabled nor reset,
  // otherwise it stepped to the wrong place.
  function automatic err_code_e mismatch_code(input logic en_prev, input logic rst_prev);
    return (!en_prev && !rst_prev) ? ErrNoEnable : ErrWrongSucc;
  endfunction

endpackage

// File: rtl/seq_next_lut.sv
// Combinational successor / legality lookup for the 3-bit sequence counter.
// Ports:
//   code  in  3  current counter code
//   succ  out 3  next code in the cycle (illegal codes map to 000)
//   legal out 1  high when code is one of the six cycle codes
module seq_next_lut
  import seq_monitor_pkg::*;
(
  input  logic [2:0] code,
  output logic [2:0] succ,
  output logic       legal
);

  always_comb begin
    succ  = S0;
    legal = 1'b1;
    unique case (code)
      S0:      succ = S1;
      S1:      succ = S2;
      S2:      succ = S3;
      S3:      succ = S4;
      S4:      succ = S5;
      S5:      succ = S0;
      default: begin
        // 100 and 110 fall off the cycle; the counter recovers to 000
        succ  = S0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_monitor.sv
// Downstream checker for the 3-bit state-sequence counter.
// Watches the counter's Q together with copies of its enable and reset, and every clock checks
// that Q moved to the correct successor or held as required.
//
// Build option: define SEQ_MONITOR_AUTO_RESYNC_EN to make FAULT last a single cycle and return
// to UNSYNC on its own; otherwise FAULT is sticky until err_clr.
//
// Ports:
//   clk       in  1      system clock, posedge
//   reset     in  1      synchronous active-low reset
//   mon_rst   in  1      copy of the counter's active-high reset
//   mon_en    in  1      copy of the counter's enable
//   q         in  3      counter output
//   err_clr   in  1      request to leave FAULT; clears err_code
//   locked    out 1      FSM is in LOCKED
//   err       out 1      one-cycle pulse per detected violation
//   err_code  out 2      last error code (00 none, 01 illegal, 10 wrong succ, 11 no enable)
//   wrap_cnt  out CNT_W  completed laps, saturating
//   err_cnt   out CNT_W  total violations, saturating
module seq_monitor
  import seq_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_rst,
  input  logic             mon_en,
  input  logic [2:0]       q,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_e     state_q, state_d;
  logic [2:0] prev_q;
  // Successor of prev_q, captured alongside it so one lookup serves both checks
  logic [2:0] prev_succ;
  logic       en_d;
  logic       rst_d;

  logic [2:0] q_succ;
  logic       q_legal;
  logic [2:0] expected;
  logic       viol;
  err_code_e  viol_code;
  logic       lap;

  seq_next_lut u_lut (
    .code  (q),
    .succ  (q_succ),
    .legal (q_legal)
  );

  // What the counter should show now, given what it was told last cycle
  always_comb begin
    expected = prev_q;
    if (rst_d) begin
      expected = S0;
    end else if (en_d) begin
      expected = prev_succ;
    end
  end

  always_comb begin
    state_d   = state_q;
    viol      = 1'b0;
    viol_code = ErrNone;
    lap       = 1'b0;
    unique case (state_q)
      StUnsync: begin
        // First legal code becomes the baseline through prev_q
        if (q_legal) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (!q_legal) begin
          viol      = 1'b1;
          viol_code = ErrIllegal;
        end else if (q != expected) begin
          viol      = 1'b1;
          viol_code = mismatch_code(en_d, rst_d);
        end else if (en_d && !rst_d && (prev_q == S5) && (q == S0)) begin
          lap = 1'b1;
        end
        if (viol) begin
          state_d = StFault;
        end
      end
      StFault: begin
`ifdef SEQ_MONITOR_AUTO_RESYNC_EN
        state_d = StUnsync;
`else
        if (err_clr) begin
          state_d = StUnsync;
        end
`endif
      end
      default: begin
        state_d = StUnsync;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StUnsync;
      prev_q    <= S0;
      prev_succ <= S1;
      en_d      <= 1'b0;
      rst_d     <= 1'b0;
      err       <= 1'b0;
      err_code  <= ErrNone;
      wrap_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= q;
      prev_succ <= q_succ;
      en_d      <= mon_en;
      rst_d     <= mon_rst;
      err       <= viol;
      // Violations only occur in LOCKED, so err_clr in FAULT never competes with a new code
      if (viol) begin
        err_code <= viol_code;
      end else if (err_clr) begin
        err_code <= ErrNone;
      end
      if (viol && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (lap && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + CNT_W'(1);
      end
    end
  end

  assign locked = (state_q == StLocked);

endmodule
